id_operand_stage: RTL and testbench
===================================

Name: id_operand_stage

Overview:
- Parametrised decode-stage operand unit for the ideal pipeline CPU. It merges the following into one block with a registered ID/EX operand bundle:
  - multi-port register file
  - HI/LO registers
  - internal forwarding-select logic
  - load-use hazard detection with stall/bubble insertion
- Unlike the previous-generation decode stage, forwarding selects are computed internally, not supplied as inputs.
- Sits between instruction decode and EX; forwarding sources come from the EX..WB stages.

Parameters:
- XLEN, 32, datapath width.
- NRD, 2, number of GPR read ports.
- NFWD, 2, number of forwarding stages; index 0 is the youngest (EX).
- ZERO_REG, 1, when 1 register 0 reads 0 and ignores writes.

Ports:
- clk  in  1  clock
- CLR  in  1  synchronous active-high reset
- flush  in  1  kill the instruction being captured into the output register
- in_valid  in  1  decoded instruction present
- in_ready  out  1  low while a hazard blocks issue
- src_num  in  NRD*5  source register numbers, port i at [5i+4:5i]
- src_en  in  NRD  port i actually reads
- hi_rd  in  1  instruction reads HI
- lo_rd  in  1  instruction reads LO
- wb_en  in  1  GPR write enable
- wb_num  in  5  GPR write index
- wb_data  in  XLEN  GPR write data
- hi_we  in  1  HI write enable
- lo_we  in  1  LO write enable
- hi_wdata  in  XLEN  HI write data
- lo_wdata  in  XLEN  LO write data
- fwd_valid  in  NFWD  stage j holds a GPR-writing instruction
- fwd_num  in  NFWD*5  destination of stage j
- fwd_ready  in  NFWD  stage j result already available (0 for a load in EX)
- fwd_hi  in  NFWD  stage j writes HI
- fwd_lo  in  NFWD  stage j writes LO
- fwd_data  in  NFWD*XLEN  stage j result
- out_valid  out  1  registered bundle valid
- out_data  out  NRD*XLEN  registered operand values
- out_hi  out  XLEN  registered HI operand
- out_lo  out  XLEN  registered LO operand
- stall_cnt  out  32  saturating count of stall cycles

Behaviour:
- Clocking and reset:
  - One clock, clk. CLR is synchronous and active-high.
  - On CLR: all GPRs, HI, LO, out_valid, out_data, out_hi, out_lo and stall_cnt become 0. CLR overrides every other input in that cycle.
- Writes:
  - GPR, HI and LO update at posedge when their enables are set.
  - Writes proceed regardless of stall or flush.
  - wb_num==0 write is dropped when ZERO_REG=1.
- Read value for port i (combinational), first match wins:
  - (a) src_num==0 with ZERO_REG=1 → 0.
  - (b) Lowest j with fwd_valid[j] and fwd_num[j]==src_num → fwd_data[j].
  - (c) wb_en and wb_num==src_num → wb_data. This is a same-cycle write bypass; it replaces the old negedge trick.
  - (d) Array contents.
- HI/LO reads follow the same order:
  - Lowest j with fwd_hi[j] (or fwd_lo[j]) → fwd_data[j].
  - Else hi_we/lo_we → the matching write data.
  - Else the register.
  - Each of HI and LO uses its own flag vector; there is no cross-use.
- Hazard:
  - Port i is hazardous when src_en[i] and its winning match in (b) has fwd_ready[j]==0.
  - HI is hazardous when hi_rd and its winning fwd_hi match is not ready; LO likewise.
  - A not-ready older stage hidden behind a ready younger match is not a hazard.
  - hazard is the OR of all of these; in_ready = !hazard.
- Output register, latency 1, evaluated in priority order:
  - CLR → cleared.
  - flush → out_valid=0, data held.
  - in_valid & !hazard → capture all operands, out_valid=1.
  - Otherwise → out_valid=0 (a bubble on stall or idle).
- stall_cnt:
  - Increments when in_valid & hazard & !flush & !CLR.
  - Saturates at 0xFFFF_FFFF with no wrap.
- Disabled ports (src_en=0) still capture whatever value they read; they never cause a stall.

Decomposition:
- Shared package id_pkg:
  - REG_W=5, NUM_GPR=32, ZERO_IDX=0.
  - Default XLEN.
  - Typedef for the ID/EX operand bundle.
- One natural sub-module, regfile_mp:
  - NRD-read, 1-write, write-through bypass.
  - Parametrised XLEN/NRD/ZERO_REG.
  - Synchronous CLR clears the array.

Test Plan:
1. Write r5=0x1234 via wb; next cycle src_num0=5, in_valid → out_data port 0 = 0x1234 one cycle later, out_valid=1.
2. Same cycle: wb r7=0xAAAA and src_num1=7 → out port 1 = 0xAAAA (write bypass); write r0=0xFFFF then read r0 → 0.
3. fwd_valid=2'b11, both fwd_num=9, fwd_data EX=0x11, MEM=0x22, ready=2'b11 → operand 0x11 (EX priority).
4. Load-use: fwd_valid[0]=1, fwd_num=3, fwd_ready[0]=0, src_num0=3 for 2 cycles:
   - in_ready=0 and out_valid=0 for both cycles; stall_cnt=2.
   - Then ready=1, fwd_data=0x55 → captured 0x55.
5. HI forward: fwd_hi[1]=1, fwd_data[1]=0xBEEF, hi_rd=1 → out_hi=0xBEEF; fwd_lo unset → out_lo = stored LO.
6. flush with in_valid & !hazard → out_valid=0. CLR mid-stall → stall_cnt=0, r5 reads 0, out_valid=0. stall_cnt preloaded to max → stays 0xFFFF_FFFF.

Source files
------------

// File: rtl/id_pkg.sv
`default_nettype none
// ============================================================================
// Package     : id_pkg
// Description : Shared constants, types and helpers for the decode-stage
//               operand unit (register file sizing, ID/EX bundle layout).
// Revision    : 1.0 - initial release
// ============================================================================
package id_pkg;

    localparam int REG_W    = 5;   // GPR index width
    localparam int NUM_GPR  = 32;  // architectural GPR count
    localparam int ZERO_IDX = 0;   // hard-wired zero register index
    localparam int XLEN_DEF = 32;  // default datapath width
    localparam int NRD_DEF  = 2;   // default number of GPR read ports

    typedef logic [REG_W-1:0] reg_idx_t;

    // ID/EX operand bundle at the default geometry
    typedef struct packed {
        logic                        valid;
        logic [NRD_DEF*XLEN_DEF-1:0] data;
        logic [XLEN_DEF-1:0]         hi;
        logic [XLEN_DEF-1:0]         lo;
    } id_ex_bundle_t;

    // True when the index names the hard-wired zero register
    function automatic logic is_zero_idx(input reg_idx_t idx);
        return idx == reg_idx_t'(ZERO_IDX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Interface   : id_operand_stage_if
// Description : Decode-side request, writeback, forwarding-network and
//               ID/EX output signals of the operand stage.
//               slave  = the operand stage, master = its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface id_operand_stage_if #(
    parameter int XLEN = id_pkg::XLEN_DEF,
    parameter int NRD  = id_pkg::NRD_DEF,
    parameter int NFWD = 2
);
    // decode request
    logic                         flush;
    logic                         in_valid;
    logic                         in_ready;
    logic [NRD*id_pkg::REG_W-1:0] src_num;
    logic [NRD-1:0]               src_en;
    logic                         hi_rd;
    logic                         lo_rd;
    // architectural writeback
    logic                         wb_en;
    logic [id_pkg::REG_W-1:0]     wb_num;
    logic [XLEN-1:0]              wb_data;
    logic                         hi_we;
    logic                         lo_we;
    logic [XLEN-1:0]              hi_wdata;
    logic [XLEN-1:0]              lo_wdata;
    // forwarding network, index 0 = youngest (EX)
    logic [NFWD-1:0]                  fwd_valid;
    logic [NFWD*id_pkg::REG_W-1:0]    fwd_num;
    logic [NFWD-1:0]                  fwd_ready;
    logic [NFWD-1:0]                  fwd_hi;
    logic [NFWD-1:0]                  fwd_lo;
    logic [NFWD*XLEN-1:0]             fwd_data;
    // registered ID/EX bundle
    logic                         out_valid;
    logic [NRD*XLEN-1:0]          out_data;
    logic [XLEN-1:0]              out_hi;
    logic [XLEN-1:0]              out_lo;
    logic [31:0]                  stall_cnt;

    modport slave (
        input  flush, in_valid, src_num, src_en, hi_rd, lo_rd,
        input  wb_en, wb_num, wb_data, hi_we, lo_we, hi_wdata, lo_wdata,
        input  fwd_valid, fwd_num, fwd_ready, fwd_hi, fwd_lo, fwd_data,
        output in_ready, out_valid, out_data, out_hi, out_lo, stall_cnt
    );

    modport master (
        output flush, in_valid, src_num, src_en, hi_rd, lo_rd,
        output wb_en, wb_num, wb_data, hi_we, lo_we, hi_wdata, lo_wdata,
        output fwd_valid, fwd_num, fwd_ready, fwd_hi, fwd_lo, fwd_data,
        input  in_ready, out_valid, out_data, out_hi, out_lo, stall_cnt
    );

endinterface
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : regfile_mp
// Description : Multi-read, single-write GPR array with same-cycle
//               write-through bypass and optional hard-wired zero register.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_mp
    import id_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NRD      = NRD_DEF,
    parameter int ZERO_REG = 1
) (
    input  wire logic                  clk,
    input  wire logic                  CLR,
    input  wire logic                  i_we,
    input  wire reg_idx_t              i_waddr,
    input  wire logic [XLEN-1:0]       i_wdata,
    input  wire logic [NRD*REG_W-1:0]  i_raddr,
    output logic      [NRD*XLEN-1:0]   o_rdata
);

    logic [XLEN-1:0] r_mem [NUM_GPR];
    logic            w_we_eff;

    // A write to the zero register is dropped entirely, so it can neither
    // land in the array nor leak through the bypass.
    assign w_we_eff = i_we && !((ZERO_REG != 0) && is_zero_idx(i_waddr));

    // Array update; writes are never gated by pipeline stalls.
    always_ff @(posedge clk) begin
        if (CLR) begin
            for (int k = 0; k < NUM_GPR; k++) begin
                r_mem[k] <= '0;
            end
        end else if (w_we_eff) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read ports: zero register, then same-cycle write bypass, then array.
    always_comb begin
        o_rdata = '0;
        for (int i = 0; i < NRD; i++) begin
            if ((ZERO_REG != 0) && is_zero_idx(i_raddr[i*REG_W +: REG_W])) begin
                o_rdata[i*XLEN +: XLEN] = '0;
            end else if (w_we_eff && (i_waddr == i_raddr[i*REG_W +: REG_W])) begin
                o_rdata[i*XLEN +: XLEN] = i_wdata;
            end else begin
                o_rdata[i*XLEN +: XLEN] = r_mem[i_raddr[i*REG_W +: REG_W]];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/id_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_operand_stage
// Description : Decode-stage operand unit. Reads GPR/HI/LO operands,
//               selects forwarded results from the EX..WB stages, detects
//               load-use hazards (stall + bubble) and registers the ID/EX
//               operand bundle with one cycle of latency.
// Revision    : 1.0 - initial release
// ============================================================================
module id_operand_stage
    import id_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NRD      = NRD_DEF,
    parameter int NFWD     = 2,
    parameter int ZERO_REG = 1
) (
    input  wire logic            clk,
    input  wire logic            CLR,
    id_operand_stage_if.slave    bus
);

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [NRD*XLEN-1:0] w_rf_rdata;
    logic [XLEN-1:0]     r_hi;
    logic [XLEN-1:0]     r_lo;

    regfile_mp #(
        .XLEN     (XLEN),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG)
    ) u_regfile (
        .clk     (clk),
        .CLR     (CLR),
        .i_we    (bus.wb_en),
        .i_waddr (bus.wb_num),
        .i_wdata (bus.wb_data),
        .i_raddr (bus.src_num),
        .o_rdata (w_rf_rdata)
    );

    // HI/LO architectural registers; writes proceed through stalls/flushes.
    always_ff @(posedge clk) begin
        if (CLR) begin
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            if (bus.hi_we) begin
                r_hi <= bus.hi_wdata;
            end
            if (bus.lo_we) begin
                r_lo <= bus.lo_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Operand selection and hazard detection
    // ------------------------------------------------------------------
    logic [NRD*XLEN-1:0] w_opnd;
    logic [NRD-1:0]      w_port_haz;
    logic [XLEN-1:0]     w_hi_val;
    logic [XLEN-1:0]     w_lo_val;
    logic                w_hi_nready;
    logic                w_lo_nready;
    logic                w_hazard;

    // GPR forwarding: scanning oldest to youngest lets the youngest match
    // overwrite, so only the winning stage's readiness decides the hazard.
    // The zero register never forwards; the regfile already returns 0.
    always_comb begin
        w_opnd     = w_rf_rdata;
        w_port_haz = '0;
        for (int i = 0; i < NRD; i++) begin
            if (!((ZERO_REG != 0) && is_zero_idx(bus.src_num[i*REG_W +: REG_W]))) begin
                for (int j = NFWD - 1; j >= 0; j--) begin
                    if (bus.fwd_valid[j] &&
                        (bus.fwd_num[j*REG_W +: REG_W] == bus.src_num[i*REG_W +: REG_W])) begin
                        w_opnd[i*XLEN +: XLEN] = bus.fwd_data[j*XLEN +: XLEN];
                        w_port_haz[i]          = bus.src_en[i] && !bus.fwd_ready[j];
                    end
                end
            end
        end
    end

    // HI/LO selection: youngest forwarding stage, else same-cycle write,
    // else the register. HI and LO each follow only their own flags.
    always_comb begin
        w_hi_val    = bus.hi_we ? bus.hi_wdata : r_hi;
        w_lo_val    = bus.lo_we ? bus.lo_wdata : r_lo;
        w_hi_nready = 1'b0;
        w_lo_nready = 1'b0;
        for (int j = NFWD - 1; j >= 0; j--) begin
            if (bus.fwd_hi[j]) begin
                w_hi_val    = bus.fwd_data[j*XLEN +: XLEN];
                w_hi_nready = !bus.fwd_ready[j];
            end
            if (bus.fwd_lo[j]) begin
                w_lo_val    = bus.fwd_data[j*XLEN +: XLEN];
                w_lo_nready = !bus.fwd_ready[j];
            end
        end
    end

    assign w_hazard     = (|w_port_haz)
                        | (bus.hi_rd && w_hi_nready)
                        | (bus.lo_rd && w_lo_nready);
    assign bus.in_ready = !w_hazard;

    // ------------------------------------------------------------------
    // ID/EX output register
    // ------------------------------------------------------------------
    logic                r_out_valid;
    logic [NRD*XLEN-1:0] r_out_data;
    logic [XLEN-1:0]     r_out_hi;
    logic [XLEN-1:0]     r_out_lo;

    // Capture on a clean issue; flush or stall leaves a bubble, data held.
    always_ff @(posedge clk) begin
        if (CLR) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_hi    <= '0;
            r_out_lo    <= '0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
        end else if (bus.in_valid && !w_hazard) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_opnd;
            r_out_hi    <= w_hi_val;
            r_out_lo    <= w_lo_val;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_hi    = r_out_hi;
    assign bus.out_lo    = r_out_lo;

    // ------------------------------------------------------------------
    // Stall statistics
    // ------------------------------------------------------------------
    logic [31:0] r_stall_cnt;
    logic        w_stall_inc;

    // Saturation is folded into the increment so the counter sticks at max.
    assign w_stall_inc = bus.in_valid && w_hazard && !bus.flush
                       && (r_stall_cnt != 32'hFFFF_FFFF);

    // Counter is rewritten every cycle (hold = add zero).
    always_ff @(posedge clk) begin
        if (CLR) begin
            r_stall_cnt <= '0;
        end else begin
            r_stall_cnt <= r_stall_cnt + {31'd0, w_stall_inc};
        end
    end

    assign bus.stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_operand_stage
// Description : Self-checking bench for id_operand_stage: vector table with
//               hand-derived expectations, an output scoreboard, and
//               hand-written multi-cycle sequences (load-use, CLR, saturation).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_operand_stage;
    import id_pkg::*;

    typedef struct {
        string       name;
        logic        in_valid;
        logic        flush;
        logic [4:0]  s0, s1;
        logic [1:0]  en;
        logic        hi_rd, lo_rd;
        logic        wb_en;
        logic [4:0]  wb_num;
        logic [31:0] wb_data;
        logic        hi_we, lo_we;
        logic [31:0] hi_wd, lo_wd;
        logic [1:0]  fv;
        logic [4:0]  fn0, fn1;
        logic [1:0]  fr, fh, fl;
        logic [31:0] fd0, fd1;
        logic        exp_ready;
        logic [31:0] e0, e1, ehi, elo;
    } vec_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    id_operand_stage_if #(.XLEN(32), .NRD(2), .NFWD(2)) bus ();

    id_operand_stage #(
        .XLEN     (32),
        .NRD      (2),
        .NFWD     (2),
        .ZERO_REG (1)
    ) dut (
        .clk (clk),
        .CLR (clr),
        .bus (bus)
    );

    int            n_tests = 0;
    int            n_fail  = 0;
    logic          mon_en  = 1'b0;
    logic [31:0]   exp_stall = '0;
    logic [63:0]   last_data = '0;
    id_ex_bundle_t sb [$];
    vec_t          vecs [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t blank(input string nm);
        vec_t v;
        v.name = nm; v.in_valid = 1'b0; v.flush = 1'b0;
        v.s0 = '0; v.s1 = '0; v.en = '0; v.hi_rd = 1'b0; v.lo_rd = 1'b0;
        v.wb_en = 1'b0; v.wb_num = '0; v.wb_data = '0;
        v.hi_we = 1'b0; v.lo_we = 1'b0; v.hi_wd = '0; v.lo_wd = '0;
        v.fv = '0; v.fn0 = '0; v.fn1 = '0; v.fr = '0; v.fh = '0; v.fl = '0;
        v.fd0 = '0; v.fd1 = '0;
        v.exp_ready = 1'b1; v.e0 = '0; v.e1 = '0; v.ehi = '0; v.elo = '0;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.in_valid  = v.in_valid;  bus.flush    = v.flush;
        bus.src_num   = {v.s1, v.s0}; bus.src_en  = v.en;
        bus.hi_rd     = v.hi_rd;     bus.lo_rd    = v.lo_rd;
        bus.wb_en     = v.wb_en;     bus.wb_num   = v.wb_num;  bus.wb_data = v.wb_data;
        bus.hi_we     = v.hi_we;     bus.lo_we    = v.lo_we;
        bus.hi_wdata  = v.hi_wd;     bus.lo_wdata = v.lo_wd;
        bus.fwd_valid = v.fv;        bus.fwd_num  = {v.fn1, v.fn0};
        bus.fwd_ready = v.fr;        bus.fwd_hi   = v.fh;      bus.fwd_lo  = v.fl;
        bus.fwd_data  = {v.fd1, v.fd0};
    endtask

    // One cycle: drive after the edge, check in_ready mid-cycle, check
    // registered state just after the next edge. Captures go to the scoreboard.
    task automatic apply(input vec_t v);
        logic        cap;
        logic [63:0] held;
        held = last_data;
        drive(v);
        cap = v.in_valid && v.exp_ready && !v.flush;
        if (cap) begin
            sb.push_back('{valid: 1'b1, data: {v.e1, v.e0}, hi: v.ehi, lo: v.elo});
            last_data = {v.e1, v.e0};
        end
        if (v.in_valid && !v.exp_ready && !v.flush && exp_stall != 32'hFFFF_FFFF)
            exp_stall++;
        @(negedge clk);
        chk({v.name, ".in_ready"}, 64'(bus.in_ready), 64'(v.exp_ready));
        @(posedge clk); #1;
        chk({v.name, ".out_valid"}, 64'(bus.out_valid), 64'(cap));
        chk({v.name, ".stall_cnt"}, 64'(bus.stall_cnt), 64'(exp_stall));
        if (v.flush) chk({v.name, ".data_held"}, bus.out_data, held);
    endtask

    task automatic do_clr(input string nm);
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        exp_stall = '0;
        last_data = '0;
        chk({nm, ".out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({nm, ".out_data"},  bus.out_data, 64'd0);
        chk({nm, ".out_hi"},    64'(bus.out_hi), 64'd0);
        chk({nm, ".out_lo"},    64'(bus.out_lo), 64'd0);
        chk({nm, ".stall_cnt"}, 64'(bus.stall_cnt), 64'd0);
    endtask

    // Scoreboard: every valid bundle must match the oldest expected capture.
    always @(negedge clk) begin
        if (mon_en && bus.out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL sb_unexpected: got out_valid=1 expected no output");
            end else begin
                id_ex_bundle_t e;
                e = sb.pop_front();
                chk("sb.out_data", bus.out_data, e.data);
                chk("sb.out_hi",   64'(bus.out_hi), 64'(e.hi));
                chk("sb.out_lo",   64'(bus.out_lo), 64'(e.lo));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        drive(blank("idle"));
        repeat (2) @(posedge clk);
        #1;
        do_clr("reset");
        chk("reset.in_ready", 64'(bus.in_ready), 64'd1);
        mon_en = 1'b1;

        // ---------------- vector table ----------------
        v = blank("wr_r5");  v.wb_en = 1; v.wb_num = 5; v.wb_data = 32'h1234; vecs.push_back(v);
        v = blank("rd_r5");  v.in_valid = 1; v.s0 = 5; v.en = 2'b01; v.e0 = 32'h1234; vecs.push_back(v);
        v = blank("wb_byp"); v.in_valid = 1; v.wb_en = 1; v.wb_num = 7; v.wb_data = 32'hAAAA;
            v.s0 = 5; v.s1 = 7; v.en = 2'b11; v.e0 = 32'h1234; v.e1 = 32'hAAAA; vecs.push_back(v);
        v = blank("wr_r0");  v.in_valid = 1; v.wb_en = 1; v.wb_num = 0; v.wb_data = 32'hFFFF;
            v.s0 = 0; v.s1 = 7; v.en = 2'b11; v.e0 = 0; v.e1 = 32'hAAAA; vecs.push_back(v);
        v = blank("rd_r0");  v.in_valid = 1; v.s0 = 0; v.s1 = 5; v.en = 2'b11;
            v.e0 = 0; v.e1 = 32'h1234; vecs.push_back(v);
        v = blank("fwd_prio"); v.in_valid = 1; v.fv = 2'b11; v.fn0 = 9; v.fn1 = 9; v.fr = 2'b11;
            v.fd0 = 32'h11; v.fd1 = 32'h22; v.s0 = 9; v.s1 = 9; v.en = 2'b11;
            v.e0 = 32'h11; v.e1 = 32'h11; vecs.push_back(v);
        v = blank("fwd_mem"); v.in_valid = 1; v.fv = 2'b10; v.fn1 = 9; v.fr = 2'b11;
            v.fd0 = 32'h11; v.fd1 = 32'h22; v.s0 = 9; v.s1 = 5; v.en = 2'b11;
            v.e0 = 32'h22; v.e1 = 32'h1234; vecs.push_back(v);
        v = blank("fwd_over_wb"); v.in_valid = 1; v.wb_en = 1; v.wb_num = 10; v.wb_data = 32'h77;
            v.fv = 2'b01; v.fn0 = 10; v.fr = 2'b01; v.fd0 = 32'h99; v.s0 = 10; v.s1 = 10; v.en = 2'b11;
            v.e0 = 32'h99; v.e1 = 32'h99; vecs.push_back(v);
        v = blank("rd_r10"); v.in_valid = 1; v.s0 = 10; v.s1 = 7; v.en = 2'b11;
            v.e0 = 32'h77; v.e1 = 32'hAAAA; vecs.push_back(v);
        v = blank("hidden_older"); v.in_valid = 1; v.fv = 2'b11; v.fn0 = 4; v.fn1 = 4; v.fr = 2'b01;
            v.fd0 = 32'h44; v.fd1 = 32'h88; v.s0 = 4; v.en = 2'b01; v.e0 = 32'h44; vecs.push_back(v);
        v = blank("dis_port"); v.in_valid = 1; v.fv = 2'b01; v.fn0 = 6; v.fr = 2'b00; v.fd0 = 32'h66;
            v.s0 = 5; v.s1 = 6; v.en = 2'b01; v.e0 = 32'h1234; v.e1 = 32'h66; vecs.push_back(v);
        v = blank("en_port_haz"); v.in_valid = 1; v.fv = 2'b01; v.fn0 = 6; v.fr = 2'b00; v.fd0 = 32'h66;
            v.s0 = 5; v.s1 = 6; v.en = 2'b11; v.exp_ready = 0; vecs.push_back(v);
        v = blank("hilo_wr"); v.in_valid = 1; v.hi_we = 1; v.hi_wd = 32'hC0DE; v.lo_we = 1; v.lo_wd = 32'hF00D;
            v.hi_rd = 1; v.lo_rd = 1; v.ehi = 32'hC0DE; v.elo = 32'hF00D; vecs.push_back(v);
        v = blank("hi_fwd"); v.in_valid = 1; v.fh = 2'b10; v.fr = 2'b11; v.fd1 = 32'hBEEF;
            v.hi_rd = 1; v.lo_rd = 1; v.ehi = 32'hBEEF; v.elo = 32'hF00D; vecs.push_back(v);
        v = blank("lo_fwd_prio"); v.in_valid = 1; v.fl = 2'b11; v.fr = 2'b11; v.fd0 = 32'h10; v.fd1 = 32'h20;
            v.hi_rd = 1; v.lo_rd = 1; v.ehi = 32'hC0DE; v.elo = 32'h10; vecs.push_back(v);
        v = blank("hi_haz"); v.in_valid = 1; v.fh = 2'b01; v.fr = 2'b00; v.fd0 = 32'h5A;
            v.hi_rd = 1; v.exp_ready = 0; vecs.push_back(v);
        v = blank("hi_unread"); v.in_valid = 1; v.fh = 2'b01; v.fr = 2'b00; v.fd0 = 32'h5A; v.lo_rd = 1;
            v.s0 = 5; v.s1 = 7; v.en = 2'b11; v.e0 = 32'h1234; v.e1 = 32'hAAAA;
            v.ehi = 32'h5A; v.elo = 32'hF00D; vecs.push_back(v);
        v = blank("lo_haz"); v.in_valid = 1; v.fl = 2'b10; v.fr = 2'b01; v.lo_rd = 1; v.exp_ready = 0;
            vecs.push_back(v);
        v = blank("flush_ok"); v.in_valid = 1; v.flush = 1; v.s0 = 5; v.en = 2'b01; vecs.push_back(v);
        v = blank("flush_haz"); v.in_valid = 1; v.flush = 1; v.fv = 2'b01; v.fn0 = 5; v.fr = 2'b00;
            v.s0 = 5; v.en = 2'b01; v.exp_ready = 0; vecs.push_back(v);
        v = blank("idle_haz"); v.fv = 2'b01; v.fn0 = 5; v.fr = 2'b00; v.s0 = 5; v.en = 2'b01;
            v.exp_ready = 0; vecs.push_back(v);

        foreach (vecs[k]) apply(vecs[k]);

        // ---------------- load-use stall then release ----------------
        do_clr("clr1");
        v = blank("load_use"); v.in_valid = 1; v.fv = 2'b01; v.fn0 = 3; v.fr = 2'b00;
        v.s0 = 3; v.en = 2'b01; v.exp_ready = 0;
        apply(v);
        apply(v);
        chk("load_use.stall2", 64'(bus.stall_cnt), 64'd2);
        v.name = "load_go"; v.fr = 2'b01; v.fd0 = 32'h55; v.exp_ready = 1; v.e0 = 32'h55;
        apply(v);

        // ---------------- CLR in the middle of a stall ----------------
        v = blank("wr_r5b"); v.wb_en = 1; v.wb_num = 5; v.wb_data = 32'h1234; apply(v);
        v = blank("pre_clr_haz"); v.in_valid = 1; v.fv = 2'b01; v.fn0 = 5; v.fr = 2'b00;
        v.s0 = 5; v.en = 2'b01; v.exp_ready = 0;
        apply(v);
        drive(v);
        do_clr("clr_mid_stall");
        v = blank("rd_r5_clr"); v.in_valid = 1; v.s0 = 5; v.en = 2'b01; v.hi_rd = 1; v.lo_rd = 1;
        apply(v);

        // ---------------- saturation ----------------
        force dut.r_stall_cnt = 32'hFFFF_FFFF;
        exp_stall = 32'hFFFF_FFFF;
        v = blank("sat_forced"); v.in_valid = 1; v.fv = 2'b01; v.fn0 = 8; v.fr = 2'b00;
        v.s0 = 8; v.en = 2'b01; v.exp_ready = 0;
        apply(v);
        release dut.r_stall_cnt;
        v.name = "sat_hold";
        apply(v);
        apply(v);
        chk("sat.max", 64'(bus.stall_cnt), 64'hFFFF_FFFF);

        drive(blank("idle"));
        repeat (3) @(posedge clk);
        #1;
        chk("sb.drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
